// File: rtl/pc_pkg.sv
// Shared types and encodings for the program-counter block.
package pc_pkg;
  typedef logic [31:0] pc_t;

  localparam logic [1:0] PC_INC_SEQ    = 2'b00;
  localparam logic [1:0] PC_INC_BRANCH = 2'b01;
  localparam logic [1:0] PC_INC_JUMP   = 2'b10;
  localparam logic [1:0] PC_INC_HOLD   = 2'b11;

  localparam pc_t PC_STEP = 32'd4;

  function automatic logic is_misaligned(pc_t a);
    return |a[1:0];
  endfunction
endpackage

// File: rtl/pc_unit_if.sv
// Control/address bundle between decode/ALU and the PC unit.
// PC_ALIGN_CHECK_EN adds the pc_misaligned flag.
interface pc_unit_if;
  import pc_pkg::*;

  logic [1:0] pc_inc;
  logic       alu_branch_result;
  pc_t        abs_addr;
  pc_t        branch_addr;
  pc_t        next_pc;
  pc_t        current_pc;
`ifdef PC_ALIGN_CHECK_EN
  logic       pc_misaligned;
`endif

  modport master (
    output pc_inc,
    output alu_branch_result,
    output abs_addr,
    output branch_addr,
`ifdef PC_ALIGN_CHECK_EN
    input  pc_misaligned,
`endif
    input  next_pc,
    input  current_pc
  );

  modport slave (
    input  pc_inc,
    input  alu_branch_result,
    input  abs_addr,
    input  branch_addr,
`ifdef PC_ALIGN_CHECK_EN
    output pc_misaligned,
`endif
    output next_pc,
    output current_pc
  );
endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, branch, jump or hold.
module pc_next_logic
  import pc_pkg::*;
(
  input  pc_t        current_pc,
  input  logic [1:0] pc_inc,
  input  logic       alu_branch_result,
  input  pc_t        abs_addr,
  input  pc_t        branch_addr,
  output pc_t        next_pc
);

  pc_t seq_pc;
  pc_t br_pc;

  always_comb begin
    seq_pc = current_pc + PC_STEP;
    br_pc  = seq_pc + (branch_addr << 2);
  end

  always_comb begin
    next_pc = seq_pc;
    unique case (1'b1)
      (pc_inc == PC_INC_SEQ):    next_pc = seq_pc;
      (pc_inc == PC_INC_BRANCH): begin
        next_pc = alu_branch_result ? br_pc : seq_pc;
      end
      (pc_inc == PC_INC_JUMP):   next_pc = abs_addr;
      (pc_inc == PC_INC_HOLD):   next_pc = current_pc;
      default:                   next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// PC register with hold and synchronous active-low clear.
// PC_ALIGN_CHECK_EN adds a sticky misaligned-PC flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       clr,
  pc_unit_if.slave   bus
);

  pc_t pc_q;
  pc_t pc_d;
  pc_t next_pc;
  logic hold;

  pc_next_logic u_next (
    .current_pc        (pc_q),
    .pc_inc            (bus.pc_inc),
    .alu_branch_result (bus.alu_branch_result),
    .abs_addr          (bus.abs_addr),
    .branch_addr       (bus.branch_addr),
    .next_pc           (next_pc)
  );

  always_comb begin
    hold = (bus.pc_inc == PC_INC_HOLD);
    pc_d = hold ? pc_q : next_pc;
  end

  always_ff @(posedge clk) begin
    if (!clr) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign bus.next_pc    = next_pc;
  assign bus.current_pc = pc_q;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;
  logic mis_d;

  // Sticky: only a load of a misaligned value sets it.
  always_comb begin
    mis_d = mis_q;
    if (!hold && is_misaligned(next_pc)) mis_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end

  assign bus.pc_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed steps then random traffic.
// Build with PC_ALIGN_CHECK_EN to also cover the alignment flag.
module tb_pc_unit;
  logic clk = 1'b0;
  logic clr = 1'b0;
  pc_unit_if bus ();

  pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic        m_valid = 1'b0;
  logic        m_mis = 1'b0;

  function automatic logic [31:0] ref_next(
    logic [31:0] pc, logic [1:0] inc, logic tk,
    logic [31:0] abs_a, logic [31:0] off);
    logic [63:0] wide;
    case (inc)
      2'd0: wide = 64'(pc) + 64'd4;
      2'd1: wide = tk ? 64'(pc) + 64'd4 + 64'(off) * 64'd4
                      : 64'(pc) + 64'd4;
      2'd2: wide = 64'(abs_a);
      default: wide = 64'(pc);
    endcase
    return wide[31:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag, logic c, logic [1:0] inc,
                      logic tk, logic [31:0] abs_a, logic [31:0] off);
    logic [31:0] exp_n;
    @(negedge clk);
    clr = c;
    bus.pc_inc = inc;
    bus.alu_branch_result = tk;
    bus.abs_addr = abs_a;
    bus.branch_addr = off;
    #1;
    exp_n = ref_next(m_pc, inc, tk, abs_a, off);
    if (m_valid) chk({tag, "_next"}, bus.next_pc, exp_n);
    @(posedge clk);
    #1;
    if (!c) begin
      m_pc = 32'h0;
      m_mis = 1'b0;
      m_valid = 1'b1;
    end else if (inc != 2'd3) begin
      m_pc = exp_n;
      if (exp_n % 4 != 0) m_mis = 1'b1;
    end
    chk({tag, "_pc"}, bus.current_pc, m_pc);
`ifdef PC_ALIGN_CHECK_EN
    checks++;
    assert (bus.pc_misaligned === m_mis) else begin
      errors++;
      $error("FAIL %s_mis got=%b exp=%b", tag,
             bus.pc_misaligned, m_mis);
    end
`endif
  endtask

  initial begin
    bus.pc_inc = 2'd0;
    bus.alu_branch_result = 1'b0;
    bus.abs_addr = '0;
    bus.branch_addr = '0;

    step("rst0", 0, 2'd0, 0, 0, 0);
    step("rst1", 0, 2'd0, 0, 0, 0);
    chk("rst_next", bus.next_pc, 32'h4);
    step("seq1", 1, 2'd0, 0, 0, 0);
    chk("seq1_lit", bus.current_pc, 32'h4);
    step("seq2", 1, 2'd0, 0, 0, 0);
    step("seq3", 1, 2'd0, 0, 0, 0);
    chk("seq3_lit", bus.current_pc, 32'hC);
    step("seq4", 1, 2'd0, 0, 0, 0);
    step("br_tk", 1, 2'd1, 1, 0, 32'h3);
    chk("br_tk_lit", bus.current_pc, 32'h20);
    step("br_bk", 1, 2'd1, 1, 0, 32'hFFFF_FFFD);
    chk("br_bk_lit", bus.current_pc, 32'h18);
    step("j10", 1, 2'd2, 1, 32'h10, 32'h7);
    step("br_nt", 1, 2'd1, 0, 0, 32'h3);
    chk("br_nt_lit", bus.current_pc, 32'h14);
    step("br_self", 1, 2'd1, 1, 0, 32'hFFFF_FFFF);
    chk("br_self_lit", bus.current_pc, 32'h14);
    step("jmp", 1, 2'd2, 1, 32'h0040_0100, 32'h5);
    chk("jmp_lit", bus.current_pc, 32'h0040_0100);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1, 2'd3, 1, 32'h1234_5678, 32'h9);
      chk("hold_lit", bus.next_pc, 32'h0040_0100);
    end
    step("seq_ah", 1, 2'd0, 0, 0, 0);
    chk("seq_ah_lit", bus.current_pc, 32'h0040_0104);
    step("j_top", 1, 2'd2, 0, 32'hFFFF_FFFC, 0);
    step("wrap", 1, 2'd0, 0, 0, 0);
    chk("wrap_lit", bus.current_pc, 32'h0);
    step("seq5", 1, 2'd0, 0, 0, 0);
    step("rst_hold", 0, 2'd3, 0, 0, 0);
    chk("rst_hold_lit", bus.current_pc, 32'h0);
    step("seq6", 1, 2'd0, 0, 0, 0);
    step("rst_jmp", 0, 2'd2, 0, 32'h1234_5678, 0);
    chk("rst_jmp_lit", bus.current_pc, 32'h0);
    step("resume", 1, 2'd0, 0, 0, 0);
    chk("resume_lit", bus.current_pc, 32'h4);
`ifdef PC_ALIGN_CHECK_EN
    step("mis_j", 1, 2'd2, 0, 32'h0000_0102, 0);
    chk("mis_j_lit", bus.current_pc, 32'h102);
    step("mis_seq", 1, 2'd0, 0, 0, 0);
    chk("mis_seq_lit", bus.current_pc, 32'h106);
    step("mis_rst", 0, 2'd0, 0, 0, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] o;
      a = $urandom;
`ifndef PC_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`else
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
`endif
      o = ($urandom_range(1) == 1) ? $urandom
          : 32'($signed($urandom_range(65535) - 32768));
      step("rnd", ($urandom_range(15) != 0),
           2'($urandom_range(3)), 1'($urandom_range(1)), a, o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
